// File: rtl/pool2_layer.sv
// pool2_layer: 2x2 stride-2 pooling of a CH x IN_DIM x IN_DIM int8 map, one output every 6 cycles.
// Average pooling by default; define POOL2_MAXPOOL_EN to build signed max pooling instead.
module pool2_layer #(
    parameter int CH     = 16,
    parameter int IN_DIM = 10,
    parameter int SRC_AW = 11,
    parameter int DST_AW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [7:0]        src_rd_data,
    output logic [DST_AW-1:0] dst_addr,
    output logic [7:0]        dst_wr_data,
    output logic              dst_wr_en
);
    localparam int OUT_DIM = IN_DIM / 2;
    localparam int CH_W    = (CH > 1) ? $clog2(CH) : 1;
    localparam int POS_W   = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD0   = 3'd1,
        S_RD1   = 3'd2,
        S_RD2   = 3'd3,
        S_RD3   = 3'd4,
        S_WAIT  = 3'd5,
        S_WRITE = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t            state_r;
    logic [CH_W-1:0]   ch_r;
    logic [POS_W-1:0]  r_r;
    logic [POS_W-1:0]  c_r;
    logic [CH_W-1:0]   nxt_ch_s;
    logic [POS_W-1:0]  nxt_r_s;
    logic [POS_W-1:0]  nxt_c_s;
    logic              last_s;
    logic signed [7:0] result_s;
`ifdef POOL2_MAXPOOL_EN
    logic signed [7:0] max_r;
`else
    logic signed [9:0] sum_r;
`endif

    function automatic logic [SRC_AW-1:0] src_index(input logic [CH_W-1:0] ch, input logic [POS_W-1:0] r,
                                                    input logic [POS_W-1:0] c, input logic dr, input logic dc);
        int unsigned idx;
        idx = 32'(ch) * IN_DIM * IN_DIM + (32'd2 * 32'(r) + 32'(dr)) * IN_DIM + 32'd2 * 32'(c) + 32'(dc);
        return SRC_AW'(idx);
    endfunction

    function automatic logic [DST_AW-1:0] dst_index(input logic [CH_W-1:0] ch, input logic [POS_W-1:0] r,
                                                    input logic [POS_W-1:0] c);
        int unsigned idx;
        idx = 32'(ch) * OUT_DIM * OUT_DIM + 32'(r) * OUT_DIM + 32'(c);
        return DST_AW'(idx);
    endfunction

    // Next output position (column innermost) and end-of-layer detection.
    always_comb begin
        nxt_ch_s = ch_r;
        nxt_r_s  = r_r;
        nxt_c_s  = c_r;
        if (c_r == POS_W'(OUT_DIM - 1)) begin
            nxt_c_s = '0;
            if (r_r == POS_W'(OUT_DIM - 1)) begin
                nxt_r_s  = '0;
                nxt_ch_s = ch_r + CH_W'(1);
            end else begin
                nxt_r_s = r_r + POS_W'(1);
            end
        end else begin
            nxt_c_s = c_r + POS_W'(1);
        end
        last_s = (ch_r == CH_W'(CH - 1)) && (r_r == POS_W'(OUT_DIM - 1)) && (c_r == POS_W'(OUT_DIM - 1));
    end

    // Pooled result: bits [9:2] of the 10-bit sum are exactly sum >>> 2, and always fit in int8.
    always_comb begin
`ifdef POOL2_MAXPOOL_EN
        result_s = max_r;
`else
        result_s = sum_r[9:2];
`endif
    end

    // Control FSM; src_addr is registered one state ahead so RDk presents tap k.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            ch_r        <= '0;
            r_r         <= '0;
            c_r         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            src_addr    <= '0;
            dst_addr    <= '0;
            dst_wr_data <= 8'd0;
            dst_wr_en   <= 1'b0;
`ifdef POOL2_MAXPOOL_EN
            max_r       <= 8'sd0;
`else
            sum_r       <= 10'sd0;
`endif
        end else begin
            dst_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r  <= S_RD0;
                        ch_r     <= '0;
                        r_r      <= '0;
                        c_r      <= '0;
                        busy     <= 1'b1;
                        src_addr <= src_index('0, '0, '0, 1'b0, 1'b0);
                    end
                end
                S_RD0: begin
                    src_addr <= src_index(ch_r, r_r, c_r, 1'b0, 1'b1);
                    state_r  <= S_RD1;
                end
                S_RD1: begin
                    src_addr <= src_index(ch_r, r_r, c_r, 1'b1, 1'b0);
`ifdef POOL2_MAXPOOL_EN
                    max_r <= $signed(src_rd_data);
`else
                    sum_r <= {{2{src_rd_data[7]}}, src_rd_data};
`endif
                    state_r <= S_RD2;
                end
                S_RD2, S_RD3, S_WAIT: begin
                    if (state_r == S_RD2) begin
                        src_addr <= src_index(ch_r, r_r, c_r, 1'b1, 1'b1);
                    end
`ifdef POOL2_MAXPOOL_EN
                    if ($signed(src_rd_data) > max_r) begin
                        max_r <= $signed(src_rd_data);
                    end
`else
                    sum_r <= sum_r + {{2{src_rd_data[7]}}, src_rd_data};
`endif
                    state_r <= (state_r == S_RD2) ? S_RD3 : ((state_r == S_RD3) ? S_WAIT : S_WRITE);
                end
                S_WRITE: begin
                    dst_addr    <= dst_index(ch_r, r_r, c_r);
                    dst_wr_data <= result_s;
                    dst_wr_en   <= 1'b1;
                    if (last_s) begin
                        state_r <= S_DONE;
                    end else begin
                        ch_r     <= nxt_ch_s;
                        r_r      <= nxt_r_s;
                        c_r      <= nxt_c_s;
                        src_addr <= src_index(nxt_ch_s, nxt_r_s, nxt_c_s, 1'b0, 1'b0);
                        state_r  <= S_RD0;
                    end
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pool2_layer.sv
// Directed self-checking bench for pool2_layer: reset, ramp data, signed windows, timing, reset robustness.
module tb_pool2_layer;
    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [10:0] src_addr;
    logic [7:0]  src_rd_data;
    logic [8:0]  dst_addr;
    logic [7:0]  dst_wr_data;
    logic        dst_wr_en;

    logic [7:0] mem_a [0:1599];
    logic [7:0] mem_b [0:399];

    int checks = 0;
    int failures = 0;

    int wr_cnt, order_err, first_wr, last_wr, done_edge, done_cnt, busy_gap, post_rst_wr, post_rst_busy;
    logic busy_e1, busy_done, rst_zero;
    logic [10:0] src0, src1;

    int wv [5][4] = '{'{-1, 0, 0, 0}, '{-128, -128, -128, -128}, '{127, 127, 127, 126},
                      '{-5, -1, -128, -3}, '{127, 0, 0, 0}};
`ifdef POOL2_MAXPOOL_EN
    int w_exp [5] = '{0, -128, 127, -1, 127};
    int ramp_hand_idx [4] = '{0, 1, 33, 34};
    int ramp_hand_exp [4] = '{11, 13, 127, 11};
`else
    int w_exp [5] = '{-1, -128, 126, -35, 31};
    int ramp_hand_idx [4] = '{0, 1, 33, 34};
    int ramp_hand_exp [4] = '{5, 7, 67, 5};
`endif

    pool2_layer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .src_addr   (src_addr),
        .src_rd_data(src_rd_data),
        .dst_addr   (dst_addr),
        .dst_wr_data(dst_wr_data),
        .dst_wr_en  (dst_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer A with one cycle of read latency.
    always @(posedge clk) begin
        src_rd_data <= (src_addr < 11'd1600) ? mem_a[src_addr] : 8'd0;
    end

    function automatic int expected_at(input int idx);
        int ch, r, c, base, t0, t1, t2, t3, m;
        ch = idx / 25;
        r = (idx % 25) / 5;
        c = idx % 5;
        base = ch * 100 + 2 * r * 10 + 2 * c;
        t0 = int'($signed(mem_a[base]));
        t1 = int'($signed(mem_a[base + 1]));
        t2 = int'($signed(mem_a[base + 10]));
        t3 = int'($signed(mem_a[base + 11]));
`ifdef POOL2_MAXPOOL_EN
        m = t0;
        if (t1 > m) m = t1;
        if (t2 > m) m = t2;
        if (t3 > m) m = t3;
`else
        m = (t0 + t1 + t2 + t3) >>> 2;
`endif
        return m;
    endfunction

    task automatic load_ramp();
        for (int i = 0; i < 1600; i++) mem_a[i] = 8'(i % 128);
    endtask

    task automatic clear_b();
        for (int i = 0; i < 400; i++) mem_b[i] = 8'h55;
    endtask

    // Pulse start, then observe n_edges edges after the start edge, optionally pulsing start/rst on given edges.
    task automatic run_layer(input int extra_start, input int rst_edge, input int n_edges);
        wr_cnt = 0; order_err = 0; first_wr = 0; last_wr = 0; done_edge = 0; done_cnt = 0;
        busy_gap = 0; post_rst_wr = 0; post_rst_busy = 0; busy_e1 = 1'b0; busy_done = 1'b1; rst_zero = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        src0 = src_addr;
        for (int k = 1; k <= n_edges; k++) begin
            @(negedge clk);
            start = (k == extra_start);
            rst = (k == rst_edge);
            @(posedge clk);
            #1;
            if (k == 1) begin
                busy_e1 = busy;
                src1 = src_addr;
            end
            if (dst_wr_en) begin
                if (int'(dst_addr) != wr_cnt) order_err++;
                if (dst_addr < 9'd400) mem_b[dst_addr] = dst_wr_data;
                wr_cnt++;
                last_wr = k;
                if (first_wr == 0) first_wr = k;
                if (rst_edge > 0 && k > rst_edge) post_rst_wr++;
            end
            if (done) begin
                done_cnt++;
                if (done_edge == 0) begin
                    done_edge = k;
                    busy_done = busy;
                end
            end
            if (rst_edge == 0 && k <= 2400 && !busy) busy_gap++;
            if (rst_edge > 0 && k == rst_edge)
                rst_zero = (busy == 1'b0 && done == 1'b0 && src_addr == 11'd0 && dst_addr == 9'd0 &&
                            dst_wr_data == 8'd0 && dst_wr_en == 1'b0);
            if (rst_edge > 0 && k > rst_edge && busy) post_rst_busy++;
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (src_addr !== 11'd0) begin failures++; $display("FAIL reset_src_addr got=%0d exp=0", src_addr); end
        checks++; if (dst_addr !== 9'd0) begin failures++; $display("FAIL reset_dst_addr got=%0d exp=0", dst_addr); end
        checks++; if (dst_wr_data !== 8'd0) begin failures++; $display("FAIL reset_dst_wr_data got=%0d exp=0", dst_wr_data); end
        checks++; if (dst_wr_en !== 1'b0) begin failures++; $display("FAIL reset_dst_wr_en got=%0b exp=0", dst_wr_en); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rst_start();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_busy got=%0b exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_start_idle got=%0b exp=0", busy); end
    endtask

    task automatic check_all_outputs(input string tag);
        for (int i = 0; i < 400; i++) begin
            checks++;
            if (int'($signed(mem_b[i])) !== expected_at(i)) begin
                failures++;
                $display("FAIL %s_data idx=%0d got=%0d exp=%0d", tag, i, $signed(mem_b[i]), expected_at(i));
            end
        end
    endtask

    task automatic test_ramp();
        load_ramp();
        clear_b();
        run_layer(0, 0, 2410);
        checks++; if (done_edge !== 2401) begin failures++; $display("FAIL ramp_done_edge got=%0d exp=2401", done_edge); end
        checks++; if (wr_cnt !== 400) begin failures++; $display("FAIL ramp_wr_count got=%0d exp=400", wr_cnt); end
        checks++; if (order_err !== 0) begin failures++; $display("FAIL ramp_order got=%0d exp=0", order_err); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'($signed(mem_b[ramp_hand_idx[i]])) !== ramp_hand_exp[i]) begin
                failures++;
                $display("FAIL ramp_hand idx=%0d got=%0d exp=%0d", ramp_hand_idx[i],
                         $signed(mem_b[ramp_hand_idx[i]]), ramp_hand_exp[i]);
            end
        end
        check_all_outputs("ramp");
    endtask

    task automatic test_timing();
        load_ramp();
        run_layer(0, 0, 2410);
        checks++; if (src0 !== 11'd0) begin failures++; $display("FAIL timing_src_e0 got=%0d exp=0", src0); end
        checks++; if (src1 !== 11'd1) begin failures++; $display("FAIL timing_src_e1 got=%0d exp=1", src1); end
        checks++; if (busy_e1 !== 1'b1) begin failures++; $display("FAIL timing_busy_e1 got=%0b exp=1", busy_e1); end
        checks++; if (busy_gap !== 0) begin failures++; $display("FAIL timing_busy_gap got=%0d exp=0", busy_gap); end
        checks++; if (first_wr !== 6) begin failures++; $display("FAIL timing_first_wr got=%0d exp=6", first_wr); end
        checks++; if (last_wr !== 2400) begin failures++; $display("FAIL timing_last_wr got=%0d exp=2400", last_wr); end
        checks++; if (done_edge !== 2401) begin failures++; $display("FAIL timing_done_edge got=%0d exp=2401", done_edge); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL timing_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (busy_done !== 1'b0) begin failures++; $display("FAIL timing_busy_at_done got=%0b exp=0", busy_done); end
    endtask

    task automatic test_windows();
        for (int i = 0; i < 1600; i++) mem_a[i] = 8'd0;
        for (int w = 0; w < 5; w++) begin
            mem_a[2 * w]      = 8'(wv[w][0]);
            mem_a[2 * w + 1]  = 8'(wv[w][1]);
            mem_a[2 * w + 10] = 8'(wv[w][2]);
            mem_a[2 * w + 11] = 8'(wv[w][3]);
        end
        clear_b();
        run_layer(0, 0, 2410);
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (int'($signed(mem_b[w])) !== w_exp[w]) begin
                failures++;
                $display("FAIL window_%0d got=%0d exp=%0d", w, $signed(mem_b[w]), w_exp[w]);
            end
        end
        checks++; if (int'($signed(mem_b[5])) !== 0) begin failures++; $display("FAIL window_zero got=%0d exp=0", $signed(mem_b[5])); end
    endtask

    task automatic test_robustness();
        load_ramp();
        clear_b();
        run_layer(100, 1000, 1100);
        checks++; if (rst_zero !== 1'b1) begin failures++; $display("FAIL robust_rst_outputs got=%0b exp=1", rst_zero); end
        checks++; if (wr_cnt !== 166) begin failures++; $display("FAIL robust_writes got=%0d exp=166", wr_cnt); end
        checks++; if (order_err !== 0) begin failures++; $display("FAIL robust_order got=%0d exp=0", order_err); end
        checks++; if (post_rst_wr !== 0) begin failures++; $display("FAIL robust_post_rst_wr got=%0d exp=0", post_rst_wr); end
        checks++; if (post_rst_busy !== 0) begin failures++; $display("FAIL robust_post_rst_busy got=%0d exp=0", post_rst_busy); end
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL robust_done got=%0d exp=0", done_cnt); end
        clear_b();
        run_layer(0, 0, 2410);
        checks++; if (done_edge !== 2401) begin failures++; $display("FAIL restart_done_edge got=%0d exp=2401", done_edge); end
        checks++; if (wr_cnt !== 400) begin failures++; $display("FAIL restart_wr_count got=%0d exp=400", wr_cnt); end
        checks++; if (order_err !== 0) begin failures++; $display("FAIL restart_order got=%0d exp=0", order_err); end
        check_all_outputs("restart");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_rst_start();
        test_ramp();
        test_timing();
        test_windows();
        test_robustness();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pool2_layer.md
# pool2_layer

Second subsampling stage of the LeNet-5 inference datapath. Reads the 16x10x10 signed int8 Conv2 activation map from buffer A, applies 2x2 stride-2 pooling per channel, and writes the 16x5x5 int8 result into buffer B for the FC1 stage. The block is a sequential FSM with a registered-read source RAM interface and registered write outputs. Average pooling is the default; max pooling is selectable at compile time.

## Interface
- CH, 16, channel count
- IN_DIM, 10, input row/column size (even); OUT_DIM = IN_DIM/2 is derived
- SRC_AW, 11, source address width (covers CH*IN_DIM*IN_DIM)
- DST_AW, 9, destination address width (covers CH*OUT_DIM*OUT_DIM)

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin layer; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until state returns to IDLE
- done  out  1  one-cycle pulse at completion
- src_addr  out  SRC_AW  buffer A read address (registered)
- src_rd_data  in  8  signed; RAM data for the address presented one cycle earlier
- dst_addr  out  DST_AW  buffer B write address (registered)
- dst_wr_data  out  8  signed pooled value (registered)
- dst_wr_en  out  1  write strobe, one cycle per output

## Operation
- States: IDLE, RD0, RD1, RD2, RD3, WAIT, WRITE, DONE.
- IDLE + start -> RD0; ch=r=c=0; busy<=1.
- RDk (k=0..3) drives src_addr = ch*IN_DIM^2 + (2r+dr)*IN_DIM + (2c+dc), with (dr,dc) = (0,0),(0,1),(1,0),(1,1) for k=0..3.
- src_rd_data for RDk is captured in the next state: RD1 loads tap 0 (acc/max cleared); RD2, RD3 and WAIT fold in taps 1-3.
- WRITE registers dst_addr = ch*OUT_DIM^2 + r*OUT_DIM + c, dst_wr_data = result, and dst_wr_en = 1.
- WRITE advances c, then r, then ch (c innermost). It goes to DONE after (CH-1, OUT_DIM-1, OUT_DIM-1); otherwise it goes to RD0.
- DONE: done<=1, busy<=0 -> IDLE.
- Average: 10-bit signed sum of 4 taps; result = sum >>> 2 (floor toward -inf), which always fits in int8. No saturation is needed.
- dst_wr_en defaults to 0 every cycle unless set by WRITE.
- start while busy (any non-IDLE state, including DONE) is ignored.
- rst in any state forces IDLE and clears all outputs. The partial results already in buffer B are left as is, and the next start restarts at ch=r=c=0.
- rst and start in the same cycle: rst wins.

## Timing
- Reset values: busy=0, done=0, src_addr=0, dst_addr=0, dst_wr_data=0, dst_wr_en=0.
- Source RAM read latency is exactly 1 cycle; no stall or back-pressure is supported.
- Each output takes 6 cycles (RD0..WRITE). A full layer is CH*OUT_DIM^2*6 = 2400 cycles.
- Edge E0 samples start. The first src_addr is valid after E0.
- The first dst_wr_en is high after E6.
- The last dst_wr_en is high after E2400.
- done is high only after E2401; busy falls on the same edge.
- The minimum start-to-start period is 2402 cycles.

## Configuration
- POOL2_MAXPOOL_EN defined: result = signed maximum of the 4 taps. The sum logic is removed, and the comparison is signed (-1 > -128).
- Not defined: average pooling as specified above.
- Cycle timing, addressing, and handshakes are identical in both builds.

## Test plan
- Ramp: buffer A[i] = i mod 128. Output (0,0,0) = floor((0+1+10+11)/4) = 5. Every dst index 0..399 is written exactly once, in ascending order.
- Negative floor: window {-1,0,0,0} -> -1; {-128,-128,-128,-128} -> -128; {127,127,127,126} -> 126.
- Max build (POOL2_MAXPOOL_EN): window {-5,-1,-128,-3} -> -1; {127,0,0,0} -> 127.
- Timing: start pulse -> done high exactly after E2401, single cycle; 400 dst_wr_en pulses; busy high from E1 to E2401.
- Robustness: pulse start at cycle 100 (ignored, no extra writes). Assert rst at cycle 1000: outputs go to 0 after that edge, and no further writes occur. A new start then completes normally with correct data.
- Golden: load layer3_conv2.mem into buffer A and compare buffer B against layer4_pool2.mem (400 bytes). Zero mismatches is required.
